// File: rtl/chacha_pkg.sv
// rtl/chacha_pkg.sv - ChaCha core shared types, quarter-round index tables and constants (CHACHA_FEEDFWD_EN adds FINAL)
package chacha_pkg;

`ifdef CHACHA_FEEDFWD_EN
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FINAL = 2'd2,
        ST_DONE  = 2'd3
    } chacha_state_e;
`else
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd3
    } chacha_state_e;
`endif

    // Word indices of (a,b,c,d) per qr_idx: 0..3 columns, 4..7 diagonals
    localparam logic [3:0] QR_A_IDX [0:7] = '{4'd0, 4'd1, 4'd2,  4'd3,  4'd0,  4'd1,  4'd2,  4'd3};
    localparam logic [3:0] QR_B_IDX [0:7] = '{4'd4, 4'd5, 4'd6,  4'd7,  4'd5,  4'd6,  4'd7,  4'd4};
    localparam logic [3:0] QR_C_IDX [0:7] = '{4'd8, 4'd9, 4'd10, 4'd11, 4'd10, 4'd11, 4'd8,  4'd9};
    localparam logic [3:0] QR_D_IDX [0:7] = '{4'd12, 4'd13, 4'd14, 4'd15, 4'd15, 4'd12, 4'd13, 4'd14};

    localparam int unsigned ROT_16 = 16;
    localparam int unsigned ROT_12 = 12;
    localparam int unsigned ROT_8  = 8;
    localparam int unsigned ROT_7  = 7;

    localparam logic [31:0] SIGMA0 = 32'h61707865;
    localparam logic [31:0] SIGMA1 = 32'h3320646e;
    localparam logic [31:0] SIGMA2 = 32'h79622d32;
    localparam logic [31:0] SIGMA3 = 32'h6b206574;

    function automatic logic [31:0] rotl32(input logic [31:0] x, input int unsigned n);
        return (x << n) | (x >> (32 - n));
    endfunction

endpackage

// File: rtl/chacha_if.sv
// rtl/chacha_if.sv - Byte-wide load/readback and start/status bus of the ChaCha core
interface chacha_if;
    logic [5:0] addr;
    logic [7:0] data_in;
    logic       wr_en;
    logic       start;
    logic [7:0] data_out;
    logic       busy;
    logic       done;

    modport master (output addr, data_in, wr_en, start, input data_out, busy, done);
    modport slave  (input addr, data_in, wr_en, start, output data_out, busy, done);
endinterface

// File: rtl/chacha_qr.sv
// rtl/chacha_qr.sv - Purely combinational ChaCha quarter-round
module chacha_qr
    import chacha_pkg::*;
(
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic [31:0] c_i,
    input  logic [31:0] d_i,
    output logic [31:0] a_o,
    output logic [31:0] b_o,
    output logic [31:0] c_o,
    output logic [31:0] d_o
);
    logic [31:0] a1, b1, c1, d1;

    assign a1  = a_i + b_i;
    assign d1  = rotl32(d_i ^ a1, ROT_16);
    assign c1  = c_i + d1;
    assign b1  = rotl32(b_i ^ c1, ROT_12);
    assign a_o = a1 + b1;
    assign d_o = rotl32(d1 ^ a_o, ROT_8);
    assign c_o = c1 + d_o;
    assign b_o = rotl32(b1 ^ c_o, ROT_7);
endmodule

// File: rtl/chacha_core.sv
// rtl/chacha_core.sv - Iterative ChaCha core, one quarter-round per cycle; CHACHA_FEEDFWD_EN adds the final state+input add
module chacha_core
    import chacha_pkg::*;
#(
    parameter int ROUNDS = 20
)
(
    input logic     clk,
    input logic     rst_n,
    chacha_if.slave host_if
);
    localparam int DR_LAST = ROUNDS / 2 - 1;

    generate
        if (ROUNDS != 8 && ROUNDS != 12 && ROUNDS != 20) begin : g_bad_rounds
            $error("chacha_core: ROUNDS must be 8, 12 or 20");
        end
    endgenerate

    chacha_state_e state_q, state_d;
    logic [31:0]   w_q [16];
    logic [31:0]   w_d [16];
    logic [2:0]    qr_idx_q, qr_idx_d;
    logic [3:0]    dr_cnt_q, dr_cnt_d;
`ifdef CHACHA_FEEDFWD_EN
    logic [31:0]   snap_q [16];
    logic [31:0]   snap_d [16];
`endif

    logic [3:0]  ia, ib, ic, id;
    logic [31:0] qa, qb, qc, qd;
    logic        run_last;

    assign ia = QR_A_IDX[qr_idx_q];
    assign ib = QR_B_IDX[qr_idx_q];
    assign ic = QR_C_IDX[qr_idx_q];
    assign id = QR_D_IDX[qr_idx_q];

    chacha_qr u_qr (
        .a_i (w_q[ia]),
        .b_i (w_q[ib]),
        .c_i (w_q[ic]),
        .d_i (w_q[id]),
        .a_o (qa),
        .b_o (qb),
        .c_o (qc),
        .d_o (qd)
    );

    assign run_last = (qr_idx_q == 3'd7) && (dr_cnt_q == 4'(DR_LAST));

    always_comb begin
        state_d  = state_q;
        w_d      = w_q;
        qr_idx_d = qr_idx_q;
        dr_cnt_d = dr_cnt_q;
`ifdef CHACHA_FEEDFWD_EN
        snap_d   = snap_q;
`endif
        case (state_q)
            ST_IDLE, ST_DONE: begin
                // A write always wins over start so loading never launches a run
                if (host_if.wr_en) begin
                    w_d[host_if.addr[5:2]][{host_if.addr[1:0], 3'b000} +: 8] = host_if.data_in;
                    state_d = ST_IDLE;
                end else if (host_if.start) begin
`ifdef CHACHA_FEEDFWD_EN
                    snap_d = w_q;
`endif
                    qr_idx_d = 3'd0;
                    dr_cnt_d = 4'd0;
                    state_d  = ST_RUN;
                end
            end
            ST_RUN: begin
                w_d[ia]  = qa;
                w_d[ib]  = qb;
                w_d[ic]  = qc;
                w_d[id]  = qd;
                qr_idx_d = qr_idx_q + 3'd1;
                if (qr_idx_q == 3'd7) begin
                    dr_cnt_d = dr_cnt_q + 4'd1;
                end
                if (run_last) begin
`ifdef CHACHA_FEEDFWD_EN
                    state_d = ST_FINAL;
`else
                    state_d = ST_DONE;
`endif
                end
            end
`ifdef CHACHA_FEEDFWD_EN
            ST_FINAL: begin
                for (int i = 0; i < 16; i++) begin
                    w_d[i] = w_q[i] + snap_q[i];
                end
                state_d = ST_DONE;
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            qr_idx_q <= 3'd0;
            dr_cnt_q <= 4'd0;
            for (int i = 0; i < 16; i++) begin
                w_q[i] <= '0;
`ifdef CHACHA_FEEDFWD_EN
                snap_q[i] <= '0;
`endif
            end
        end else begin
            state_q  <= state_d;
            qr_idx_q <= qr_idx_d;
            dr_cnt_q <= dr_cnt_d;
            w_q      <= w_d;
`ifdef CHACHA_FEEDFWD_EN
            snap_q   <= snap_d;
`endif
        end
    end

    assign host_if.data_out = w_q[host_if.addr[5:2]][{host_if.addr[1:0], 3'b000} +: 8];
    assign host_if.busy     = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign host_if.done     = (state_q == ST_DONE);
endmodule

// File: tb/tb_chacha_core.sv
// tb/tb_chacha_core.sv - Bench for chacha_core at ROUNDS 20/12/8 with a block-function reference model
module tb_chacha_core;
    import chacha_pkg::*;

    typedef logic [15:0][31:0] blk_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] addr = '0;
    logic [7:0] data_in = '0;
    logic       wr_en = 1'b0;
    logic       start = 1'b0;
    logic [2:0] busy_v;
    logic [2:0] done_v;
    logic [7:0] dout_v [3];

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int RG = (g == 0) ? 20 : (g == 1) ? 12 : 8;
        chacha_if bus_i ();
        assign bus_i.addr    = addr;
        assign bus_i.data_in = data_in;
        assign bus_i.wr_en   = wr_en;
        assign bus_i.start   = start;
        assign busy_v[g]     = bus_i.busy;
        assign done_v[g]     = bus_i.done;
        assign dout_v[g]     = bus_i.data_out;
        chacha_core #(.ROUNDS(RG)) u_dut (
            .clk     (clk),
            .rst_n   (rst_n),
            .host_if (bus_i)
        );
    end

    logic [31:0] ua, ub, uc, ud, ya, yb, yc, yd;
    chacha_qr u_qr_ut (
        .a_i (ua), .b_i (ub), .c_i (uc), .d_i (ud),
        .a_o (ya), .b_o (yb), .c_o (yc), .d_o (yd)
    );

    function automatic int rounds_of(input int k);
        return (k == 0) ? 20 : (k == 1) ? 12 : 8;
    endfunction

    function automatic int ff_extra();
`ifdef CHACHA_FEEDFWD_EN
        return 1;
`else
        return 0;
`endif
    endfunction

    function automatic logic [31:0] rl(input logic [31:0] v, input int n);
        return (v << n) | (v >> (32 - n));
    endfunction

    function automatic blk_t qrm(input blk_t s, input int a, input int b, input int c, input int d);
        s[a] = s[a] + s[b]; s[d] = rl(s[d] ^ s[a], 16);
        s[c] = s[c] + s[d]; s[b] = rl(s[b] ^ s[c], 12);
        s[a] = s[a] + s[b]; s[d] = rl(s[d] ^ s[a], 8);
        s[c] = s[c] + s[d]; s[b] = rl(s[b] ^ s[c], 7);
        return s;
    endfunction

    function automatic blk_t model_block(input blk_t in, input int rounds);
        blk_t x = in;
        for (int r = 0; r < rounds / 2; r++) begin
            x = qrm(x, 0, 4, 8, 12);
            x = qrm(x, 1, 5, 9, 13);
            x = qrm(x, 2, 6, 10, 14);
            x = qrm(x, 3, 7, 11, 15);
            x = qrm(x, 0, 5, 10, 15);
            x = qrm(x, 1, 6, 11, 12);
            x = qrm(x, 2, 7, 8, 13);
            x = qrm(x, 3, 4, 9, 14);
        end
        if (ff_extra() == 1) begin
            for (int i = 0; i < 16; i++) x[i] = x[i] + in[i];
        end
        return x;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic read_word(input int k, input int w, output logic [31:0] v);
        logic [3:0] wi;
        wi = w[3:0];
        for (int b = 0; b < 4; b++) begin
            addr = {wi, b[1:0]};
            #1;
            v[8*b +: 8] = dout_v[k];
        end
    endtask

    task automatic check_state(input string tag, input int k, input blk_t exp);
        logic [31:0] v;
        for (int i = 0; i < 16; i++) begin
            read_word(k, i, v);
            chk($sformatf("%s d%0d w%0d", tag, k, i), v, exp[i]);
        end
    endtask

    task automatic load(input blk_t st);
        for (int i = 0; i < 64; i++) begin
            addr    = i[5:0];
            data_in = st[i / 4][8 * (i % 4) +: 8];
            wr_en   = 1'b1;
            step();
        end
        wr_en = 1'b0;
    endtask

    // Starts all three cores together and checks latency, busy span and final state
    task automatic run_check(input blk_t st, input string tag, input int disturb_at);
        int lat [3];
        int bcnt [3];
        int cyc;
        for (int k = 0; k < 3; k++) begin lat[k] = 0; bcnt[k] = 0; end
        start = 1'b1;
        step();
        start = 1'b0;
        cyc = 1;
        while (cyc < 200) begin
            for (int k = 0; k < 3; k++) begin
                if (busy_v[k]) bcnt[k]++;
                if (done_v[k] && lat[k] == 0) lat[k] = cyc;
            end
            if (lat[0] != 0 && lat[1] != 0 && lat[2] != 0) break;
            if (cyc == disturb_at) begin
                wr_en   = 1'b1;
                start   = 1'b1;
                addr    = 6'($urandom);
                data_in = 8'($urandom);
            end
            step();
            wr_en = 1'b0;
            start = 1'b0;
            cyc++;
        end
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("%s latency d%0d", tag, k), 32'(lat[k]), 32'(rounds_of(k) * 4 + 1 + ff_extra()));
            chk($sformatf("%s busy_cycles d%0d", tag, k), 32'(bcnt[k]), 32'(rounds_of(k) * 4 + ff_extra()));
            check_state(tag, k, model_block(st, rounds_of(k)));
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        blk_t st;
        blk_t zero;
        logic [31:0] v;
        zero = '0;

        do_reset();
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("reset busy d%0d", k), 32'(busy_v[k]), 32'd0);
            chk($sformatf("reset done d%0d", k), 32'(done_v[k]), 32'd0);
            check_state("reset", k, zero);
        end

        ua = 32'h11111111; ub = 32'h01020304; uc = 32'h9b8d6f43; ud = 32'h01234567;
        #1;
        chk("qr_unit a", ya, 32'hea2a92f4);
        chk("qr_unit b", yb, 32'hcb1cf8ce);
        chk("qr_unit c", yc, 32'h4581472e);
        chk("qr_unit d", yd, 32'h5881c4bb);

        st[0] = SIGMA0; st[1] = SIGMA1; st[2] = SIGMA2; st[3] = SIGMA3;
        st[4]  = 32'h03020100; st[5]  = 32'h07060504; st[6]  = 32'h0b0a0908; st[7]  = 32'h0f0e0d0c;
        st[8]  = 32'h13121110; st[9]  = 32'h17161514; st[10] = 32'h1b1a1918; st[11] = 32'h1f1e1d1c;
        st[12] = 32'h00000001; st[13] = 32'h09000000; st[14] = 32'h4a000000; st[15] = 32'h00000000;
        load(st);
        run_check(st, "rfc", -1);
        read_word(0, 0, v);
`ifdef CHACHA_FEEDFWD_EN
        chk("rfc_vec w0", v, 32'he4e7f110);
        read_word(0, 1, v);
        chk("rfc_vec w1", v, 32'h15593bd1);
`else
        chk("rfc_vec w0", v, 32'h837778ab);
        read_word(0, 1, v);
        chk("rfc_vec w1", v, 32'he238d763);
`endif

        do_reset();
        run_check(zero, "zero", -1);
        check_state("zero_direct", 2, zero);

        for (int t = 0; t < 3; t++) begin
            for (int i = 0; i < 16; i++) st[i] = $urandom;
            load(st);
            run_check(st, $sformatf("rand%0d", t), -1);
        end

        for (int i = 0; i < 16; i++) st[i] = $urandom;
        load(st);
        run_check(st, "disturb", 5);

        for (int i = 0; i < 16; i++) st[i] = $urandom;
        load(st);
        start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 1; c < 10; c++) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("midrst busy d%0d", k), 32'(busy_v[k]), 32'd0);
            chk($sformatf("midrst done d%0d", k), 32'(done_v[k]), 32'd0);
            check_state("midrst", k, zero);
        end
        for (int i = 0; i < 16; i++) st[i] = $urandom;
        load(st);
        run_check(st, "after_rst", -1);

        do_reset();
        addr    = 6'h05;
        data_in = 8'ha5;
        wr_en   = 1'b1;
        start   = 1'b1;
        step();
        wr_en   = 1'b0;
        start   = 1'b0;
        step();
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("wr_start busy d%0d", k), 32'(busy_v[k]), 32'd0);
            read_word(k, 1, v);
            chk($sformatf("wr_start byte d%0d", k), v, 32'h0000a500);
        end
        st = zero;
        st[1] = 32'h0000a500;
        run_check(st, "wr_then_start", -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
